// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a circular write-side FIFO.
// Each frame is one start bit, eight data bits (LSB first) and one stop bit,
// every bit lasting prescaler+1 clock cycles. Frames run back to back while
// bytes are queued and the transmitter is enabled.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          en,
    input  logic [DIV_W-1:0]              prescaler,
    input  logic [7:0]                    wdata,
    input  logic                          wr,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done
);

    // Pointer width carries one extra wrap bit so full and empty differ.
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    level_reg;
    logic             full_reg;
    logic             empty_reg;
    logic             overflow_reg;

    // Transmit engine
    state_t           state_reg;
    logic [7:0]       shift_reg;
    logic [DIV_W-1:0] bit_len_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic             tx_reg;
    logic             busy_reg;
    logic             tx_done_reg;

    // Combinational handshakes between the FIFO and the engine
    logic             bit_end;
    logic             push;
    logic             pop;
    logic [PW-1:0]    wr_ptr_next;
    logic [PW-1:0]    rd_ptr_next;
    logic [PW-1:0]    level_next;
    logic             full_next;
    logic             empty_next;

    // Decide this cycle's push/pop and derive the post-edge FIFO flags.
    always_comb begin
        bit_end     = (cnt_reg == bit_len_reg);
        // A write against a full FIFO is refused even if a pop happens now.
        push        = wr && !full_reg;
        // A new frame may start from IDLE, or straight out of the last stop-bit cycle.
        pop         = en && !empty_reg &&
                      ((state_reg == IDLE) || ((state_reg == STOP) && bit_end));
        wr_ptr_next = push ? (wr_ptr_reg + PW'(1)) : wr_ptr_reg;
        rd_ptr_next = pop  ? (rd_ptr_reg + PW'(1)) : rd_ptr_reg;
        level_next  = wr_ptr_next - rd_ptr_next;
        empty_next  = (wr_ptr_next == rd_ptr_next);
        full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                      (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    end

    // Byte storage; no reset so the array maps onto plain RAM.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    // Pointer, occupancy and overflow registers; reset flushes the FIFO.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            full_reg     <= full_next;
            empty_reg    <= empty_next;
            overflow_reg <= wr && full_reg;
        end
    end

    // Frame sequencer: every output is registered so tx never glitches.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_len_reg <= '0;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            tx_done_reg <= 1'b0;
        end else begin
            tx_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                    if (pop) begin
                        // Latch the divider so later prescaler writes wait for the next frame.
                        shift_reg   <= mem[rd_ptr_reg[AW-1:0]];
                        bit_len_reg <= prescaler;
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        tx_reg      <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_reg   <= '0;
                        tx_reg    <= shift_reg[0];
                        state_reg <= DATA;
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            tx_reg      <= 1'b1;
                            state_reg   <= STOP;
                            // A one-cycle stop bit is its own last cycle.
                            tx_done_reg <= (bit_len_reg == '0);
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_reg <= '0;
                        if (pop) begin
                            // Chain straight into the next start bit, no idle gap.
                            shift_reg   <= mem[rd_ptr_reg[AW-1:0]];
                            bit_len_reg <= prescaler;
                            bit_idx_reg <= '0;
                            tx_reg      <= 1'b0;
                            busy_reg    <= 1'b1;
                            state_reg   <= START;
                        end else begin
                            tx_reg    <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                        // Flag the cycle that will be the final one of the stop bit.
                        tx_done_reg <= ((cnt_reg + DIV_W'(1)) == bit_len_reg);
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign full     = full_reg;
    assign empty    = empty_reg;
    assign level    = level_reg;
    assign overflow = overflow_reg;
    assign tx       = tx_reg;
    assign busy     = busy_reg;
    assign tx_done  = tx_done_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a queue-based frame
// model compared every cycle, plus literal expectations for each scenario.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] prescaler = '0;
    logic [7:0]    wdata = '0;
    logic          wr = 1'b0;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          tx;
    logic          busy;
    logic          tx_done;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .en        (en),
        .prescaler (prescaler),
        .wdata     (wdata),
        .wr        (wr),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 HCLK = ~HCLK;

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // A frame is a 10-bit vector {stop, data, start}; the line shows bit
    // t/(p+1) at cycle t of the frame, and the frame lasts 10*(p+1) cycles.
    logic [7:0] m_q[$];
    bit         m_active = 0;
    int         m_t = 0;
    int         m_p = 0;
    logic [9:0] m_frame = '1;
    bit         m_ovf = 0;
    bit         m_valid = 0;

    always @(posedge HCLK) begin : model_b
        bit         was_full;
        bit         was_empty;
        bit         take;
        logic [7:0] b;
        if (!HRESETn) begin
            m_q.delete();
            m_active = 0;
            m_t      = 0;
            m_ovf    = 0;
        end else begin
            was_full  = (m_q.size() == DEPTH);
            was_empty = (m_q.size() == 0);
            take      = 0;
            if (m_active) begin
                if (m_t == 10 * (m_p + 1) - 1) begin
                    m_active = 0;
                    take     = en && !was_empty;
                end else begin
                    m_t++;
                end
            end else begin
                take = en && !was_empty;
            end
            if (take) begin
                b        = m_q.pop_front();
                m_frame  = {1'b1, b, 1'b0};
                m_p      = int'(prescaler);
                m_t      = 0;
                m_active = 1;
            end
            m_ovf = wr && was_full;
            if (wr && !was_full) m_q.push_back(wdata);
        end
        m_valid = 1;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge HCLK) begin : cmp_b
        int exp_tx;
        int exp_done;
        if (m_valid) begin
            exp_tx   = m_active ? int'(m_frame[m_t / (m_p + 1)]) : 1;
            exp_done = (m_active && (m_t == 10 * (m_p + 1) - 1)) ? 1 : 0;
            check("tx",       int'(tx),       exp_tx);
            check("busy",     int'(busy),     m_active ? 1 : 0);
            check("tx_done",  int'(tx_done),  exp_done);
            check("level",    int'(level),    m_q.size());
            check("full",     int'(full),     (m_q.size() == DEPTH) ? 1 : 0);
            check("empty",    int'(empty),    (m_q.size() == 0) ? 1 : 0);
            check("overflow", int'(overflow), m_ovf ? 1 : 0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr    = 1'b1;
        wdata = d;
        tick();
        wr    = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && busy; k++) tick();
        check("wait_idle", int'(busy), 0);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: run exceeded 2 ms, expected completion well before");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int samp[200];
        int busy_cnt;
        int done_cnt;
        int done_at;
        int max_lvl;
        int rises;
        int prev_busy;
        int a41[10];
        int alt[10];
        logic [7:0] hi[4];

        a41 = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
        alt = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        hi  = '{8'h48, 8'h69, 8'h21, 8'h0A};

        // Reset state
        tick();
        tick();
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_level", int'(level), 0);
        check("rst_full", int'(full), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_tx_done", int'(tx_done), 0);
        HRESETn = 1'b1;
        tick();

        // Single byte 0x41 at prescaler 15
        prescaler = 16'd15;
        en        = 1'b1;
        push_byte(8'h41);
        check("a_empty_after_write", int'(empty), 0);
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int i = 0; i < 180; i++) begin
            tick();
            samp[i] = int'(tx);
            busy_cnt += int'(busy);
            if (tx_done) begin done_cnt++; done_at = i; end
        end
        check("a_start_latency", samp[0], 0);
        for (int b = 0; b < 10; b++) check($sformatf("a_bit%0d", b), samp[b * 16 + 8], a41[b]);
        check("a_busy_cycles", busy_cnt, 160);
        check("a_done_count", done_cnt, 1);
        check("a_done_cycle", done_at, 159);

        // Burst "Hi!\n"
        max_lvl = 0; busy_cnt = 0; done_cnt = 0; rises = 0; prev_busy = 0;
        for (int j = 0; j < 4; j++) begin
            wr = 1'b1; wdata = hi[j];
            tick();
            if (int'(level) > max_lvl) max_lvl = int'(level);
            busy_cnt += int'(busy);
            if (busy && prev_busy == 0) rises++;
            prev_busy = int'(busy);
        end
        wr = 1'b0;
        for (int i = 0; i < 700; i++) begin
            tick();
            if (int'(level) > max_lvl) max_lvl = int'(level);
            busy_cnt += int'(busy);
            done_cnt += int'(tx_done);
            if (busy && prev_busy == 0) rises++;
            prev_busy = int'(busy);
        end
        check("burst_level_peak", max_lvl, 3);
        check("burst_busy_cycles", busy_cnt, 640);
        check("burst_busy_rises", rises, 1);
        check("burst_done_count", done_cnt, 4);

        // Overflow with transmitter disabled
        en = 1'b0;
        for (int j = 0; j < 16; j++) push_byte(8'(j + 8'h30));
        check("ovf_full", int'(full), 1);
        check("ovf_level16", int'(level), 16);
        check("ovf_no_pulse_yet", int'(overflow), 0);
        push_byte(8'hEE);
        check("ovf_pulse", int'(overflow), 1);
        check("ovf_level_kept", int'(level), 16);
        tick();
        check("ovf_pulse_single", int'(overflow), 0);
        en = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 2600; i++) begin
            tick();
            done_cnt += int'(tx_done);
        end
        check("ovf_frames_sent", done_cnt, 16);
        check("ovf_drained", int'(empty), 1);

        // Mid-frame prescaler change and enable drop
        prescaler = 16'd15;
        push_byte(8'hA5);
        push_byte(8'h3C);
        busy_cnt = int'(busy);
        for (int i = 0; i < 200; i++) begin
            if (i == 30) begin
                prescaler = 16'd3;
                en        = 1'b0;
            end
            tick();
            busy_cnt += int'(busy);
        end
        check("mid_first_frame_cycles", busy_cnt, 160);
        check("mid_level_held", int'(level), 1);
        check("mid_tx_idle", int'(tx), 1);
        en = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            busy_cnt += int'(busy);
            done_cnt += int'(tx_done);
        end
        check("mid_second_frame_cycles", busy_cnt, 40);
        check("mid_second_done", done_cnt, 1);

        // Reset during DATA bit 3 with two bytes queued
        prescaler = 16'd15;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        check("rmid_level_before", int'(level), 2);
        for (int i = 0; i < 70; i++) tick();
        check("rmid_busy_before", int'(busy), 1);
        HRESETn = 1'b0;
        tick();
        check("rmid_tx", int'(tx), 1);
        check("rmid_busy", int'(busy), 0);
        check("rmid_level", int'(level), 0);
        check("rmid_empty", int'(empty), 1);
        HRESETn = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            busy_cnt += int'(busy);
        end
        check("rmid_no_resume", busy_cnt, 0);

        // prescaler 0 with 0x55
        prescaler = 16'd0;
        push_byte(8'h55);
        done_at = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            samp[i] = int'(tx);
            if (tx_done) done_at = i;
        end
        for (int b = 0; b < 10; b++) check($sformatf("p0_bit%0d", b), samp[b], alt[b]);
        check("p0_done_cycle", done_at, 9);

        // Simultaneous write and pop keeps level
        en = 1'b0;
        push_byte(8'h01);
        push_byte(8'h02);
        check("wp_level_before", int'(level), 2);
        en    = 1'b1;
        wr    = 1'b1;
        wdata = 8'h03;
        tick();
        wr = 1'b0;
        check("wp_level_same", int'(level), 2);
        check("wp_busy", int'(busy), 1);
        wait_idle(100);
        check("wp_drained", int'(empty), 1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
